// File: rtl/sr_pulse_gen.sv
// rtl/sr_pulse_gen.sv - debounced, mutually exclusive S/R pulse generator
//
// Purpose: turns two raw, asynchronous, bouncy request lines into clean,
// fixed-width S/R pulses with a minimum gap, so the downstream SR flip-flop
// never sees S and R high together.
//
// Ports:
//   Clk        in   single clock, all logic on posedge
//   Rst_n      in   synchronous active-low reset
//   Set_req    in   raw asynchronous set request, active high
//   Reset_req  in   raw asynchronous reset request, active high
//   S          out  registered set pulse to the flip-flop
//   R          out  registered reset pulse to the flip-flop
//   Busy       out  high while pulsing or in the post-pulse gap
//   Conflict   out  one-cycle flag when a simultaneous pending request is dropped
//   Q_shadow   out  (SR_PULSE_SHADOW_EN only) expected flip-flop state
//
// Optional feature macro: SR_PULSE_SHADOW_EN
module sr_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_WIDTH     = 1,
  parameter int unsigned GAP_CYCLES      = 1,
  parameter bit          RESET_PRIORITY  = 1'b1,
  parameter int unsigned CNT_W           = 8
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Set_req,
  input  logic Reset_req,
  output logic S,
  output logic R,
  output logic Busy,
  output logic Conflict
`ifdef SR_PULSE_SHADOW_EN
  ,
  output logic Q_shadow
`endif
);

  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] PW_LIM  = CNT_W'(PULSE_WIDTH);
  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE_S, ST_PULSE_R, ST_GAP} state_t;

  // Channel index 0 is the set request, index 1 the reset request.
  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       deb_q, deb_d;
  logic [CNT_W-1:0] deb_cnt_q [2];
  logic [CNT_W-1:0] deb_cnt_d [2];
  logic [1:0]       pend_q, pend_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             busy_q, busy_d;
  logic             conflict_q, conflict_d;
  logic [1:0]       evt;
  logic [1:0]       pend_clr;
  logic [1:0]       want;
`ifdef SR_PULSE_SHADOW_EN
  logic             shadow_q, shadow_d;
  logic [1:0]       redundant;
`endif

  always_comb begin
    sync1_d = {Reset_req, Set_req};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    evt     = 2'b00;
    for (int c = 0; c < 2; c++) begin
      deb_cnt_d[c] = '0;
      if (sync2_q[c] != deb_q[c]) begin
        if (deb_cnt_q[c] + ONE == DEB_LIM) begin
          deb_d[c] = sync2_q[c];
          // Only a rising debounced level is a request; release is silent.
          evt[c]   = sync2_q[c];
        end else begin
          deb_cnt_d[c] = deb_cnt_q[c] + ONE;
        end
      end
    end

    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_clr   = 2'b00;
    conflict_d = 1'b0;
    want       = pend_q;
`ifdef SR_PULSE_SHADOW_EN
    shadow_d  = shadow_q;
    // Requests that would not change the flip-flop are discarded unserved.
    redundant = {pend_q[1] & ~shadow_q, pend_q[0] & shadow_q};
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
`ifdef SR_PULSE_SHADOW_EN
        want     = pend_q & ~redundant;
        pend_clr = redundant;
`endif
        if (want == 2'b11) begin
          conflict_d = 1'b1;
          pend_clr   = 2'b11;
          state_d    = RESET_PRIORITY ? ST_PULSE_R : ST_PULSE_S;
        end else if (want[0]) begin
          pend_clr = pend_clr | 2'b01;
          state_d  = ST_PULSE_S;
        end else if (want[1]) begin
          pend_clr = pend_clr | 2'b10;
          state_d  = ST_PULSE_R;
        end
      end
      ST_PULSE_S, ST_PULSE_R: begin
        if (cnt_q + ONE == PW_LIM) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
`ifdef SR_PULSE_SHADOW_EN
          shadow_d = (state_q == ST_PULSE_S);
`endif
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        if (cnt_q + ONE == GAP_LIM) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase

    // A new event on the same edge as a clear keeps the flag set.
    pend_d = (pend_q & ~pend_clr) | evt;
    s_d    = (state_d == ST_PULSE_S);
    r_d    = (state_d == ST_PULSE_R);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sync1_q      <= 2'b00;
      sync2_q      <= 2'b00;
      deb_q        <= 2'b00;
      deb_cnt_q[0] <= '0;
      deb_cnt_q[1] <= '0;
      pend_q       <= 2'b00;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      busy_q       <= 1'b0;
      conflict_q   <= 1'b0;
`ifdef SR_PULSE_SHADOW_EN
      shadow_q     <= 1'b0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      deb_cnt_q[0] <= deb_cnt_d[0];
      deb_cnt_q[1] <= deb_cnt_d[1];
      pend_q       <= pend_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s_q          <= s_d;
      r_q          <= r_d;
      busy_q       <= busy_d;
      conflict_q   <= conflict_d;
`ifdef SR_PULSE_SHADOW_EN
      shadow_q     <= shadow_d;
`endif
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign Busy     = busy_q;
  assign Conflict = conflict_q;
`ifdef SR_PULSE_SHADOW_EN
  assign Q_shadow = shadow_q;
`endif

endmodule

// File: tb/tb_sr_pulse_gen.sv
// tb/tb_sr_pulse_gen.sv - self-checking bench for sr_pulse_gen
module tb_sr_pulse_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       set_req;
  logic       reset_req;
  logic [2:0] s, r, busy, conflict;

  always #5 clk = ~clk;

  // Three configurations share the same stimulus.
  sr_pulse_gen #(.DEBOUNCE_CYCLES(4), .PULSE_WIDTH(1), .GAP_CYCLES(1), .RESET_PRIORITY(1'b1), .CNT_W(8)) u0 (
    .Clk(clk), .Rst_n(rst_n), .Set_req(set_req), .Reset_req(reset_req),
    .S(s[0]), .R(r[0]), .Busy(busy[0]), .Conflict(conflict[0]));
  sr_pulse_gen #(.DEBOUNCE_CYCLES(4), .PULSE_WIDTH(1), .GAP_CYCLES(0), .RESET_PRIORITY(1'b0), .CNT_W(8)) u1 (
    .Clk(clk), .Rst_n(rst_n), .Set_req(set_req), .Reset_req(reset_req),
    .S(s[1]), .R(r[1]), .Busy(busy[1]), .Conflict(conflict[1]));
  sr_pulse_gen #(.DEBOUNCE_CYCLES(2), .PULSE_WIDTH(3), .GAP_CYCLES(2), .RESET_PRIORITY(1'b1), .CNT_W(8)) u2 (
    .Clk(clk), .Rst_n(rst_n), .Set_req(set_req), .Reset_req(reset_req),
    .S(s[2]), .R(r[2]), .Busy(busy[2]), .Conflict(conflict[2]));

  int cfg_d   [3] = '{4, 4, 2};
  int cfg_pw  [3] = '{1, 1, 3};
  int cfg_gap [3] = '{1, 0, 2};
  int cfg_rp  [3] = '{1, 0, 1};

  localparam int HIST = 4096;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rst = 0;
  bit raw_hist [2][HIST];

  // Model state: debounced level and mismatch run length per channel, pending
  // flags, and the current pulse described by its start edge and channel.
  bit m_deb    [3][2];
  int m_run    [3][2];
  bit m_pend   [3][2];
  bit m_active [3];
  int m_start  [3];
  int m_ch     [3];
  bit e_s [3];
  bit e_r [3];
  bit e_b [3];
  bit e_c [3];

  task automatic chk(input string name, input int k, input logic act, input bit exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at edge %0d: got %b want %b", name, k, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int k, input bit nv);
    bit clr [2];
    bit evt [2];
    bit lvl;
    bit conf;
    clr[0] = 0; clr[1] = 0; evt[0] = 0; evt[1] = 0; conf = 0;
    if (!nv) begin
      for (int c = 0; c < 2; c++) begin
        m_deb[k][c] = 0; m_run[k][c] = 0; m_pend[k][c] = 0;
      end
      m_active[k] = 0;
      e_s[k] = 0; e_r[k] = 0; e_b[k] = 0; e_c[k] = 0;
      return;
    end
    // A pulse occupies PW edges, then GAP edges, then one idle edge before the next start.
    if (m_active[k] && cyc >= m_start[k] + cfg_pw[k] + cfg_gap[k] + 1)
      m_active[k] = 0;
    if (!m_active[k]) begin
      if (m_pend[k][0] && m_pend[k][1]) begin
        conf = 1; clr[0] = 1; clr[1] = 1;
        m_ch[k] = cfg_rp[k];
        m_active[k] = 1; m_start[k] = cyc;
      end else if (m_pend[k][0] || m_pend[k][1]) begin
        m_ch[k] = m_pend[k][0] ? 0 : 1;
        clr[m_ch[k]] = 1;
        m_active[k] = 1; m_start[k] = cyc;
      end
    end
    for (int c = 0; c < 2; c++) begin
      // The debouncer sees the raw level two edges late, zero if a reset intervened.
      lvl = (cyc - 2 > last_rst) ? raw_hist[c][cyc-2] : 1'b0;
      if (lvl != m_deb[k][c]) begin
        m_run[k][c]++;
        if (m_run[k][c] == cfg_d[k]) begin
          m_deb[k][c] = lvl;
          m_run[k][c] = 0;
          evt[c] = lvl;
        end
      end else begin
        m_run[k][c] = 0;
      end
      m_pend[k][c] = (m_pend[k][c] && !clr[c]) || evt[c];
    end
    e_s[k] = m_active[k] && m_ch[k] == 0 && cyc < m_start[k] + cfg_pw[k];
    e_r[k] = m_active[k] && m_ch[k] == 1 && cyc < m_start[k] + cfg_pw[k];
    e_b[k] = m_active[k] && cyc < m_start[k] + cfg_pw[k] + cfg_gap[k];
    e_c[k] = conf;
  endtask

  // One clock: drive at the falling edge, let the rising edge sample, check at the next falling edge.
  task automatic tick(input bit sv, input bit rv, input bit nv);
    set_req = sv; reset_req = rv; rst_n = nv;
    cyc++;
    if (cyc >= HIST) begin
      errors++;
      $display("FAIL history_overflow at edge %0d: got %0d want below %0d", cyc, cyc, HIST);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "history overflow");
    end
    raw_hist[0][cyc] = sv;
    raw_hist[1][cyc] = rv;
    if (!nv) last_rst = cyc;
    for (int k = 0; k < 3; k++) model_step(k, nv);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("s", k, s[k], e_s[k]);
      chk("r", k, r[k], e_r[k]);
      chk("busy", k, busy[k], e_b[k]);
      chk("conflict", k, conflict[k], e_c[k]);
      chk("s_and_r", k, s[k] & r[k], 1'b0);
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 30; i++) tick(0, 0, 1);
  endtask

  int sc [3];
  int rc [3];
  int cc [3];
  int hold_s, hold_r;
  bit lvl_s, lvl_r;

  initial begin
    set_req = 0; reset_req = 0; rst_n = 0;

    // Reset held with Set_req high; then first-pulse latency.
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0);
      for (int k = 0; k < 3; k++) begin
        chk("rst_s", k, s[k], 1'b0);
        chk("rst_r", k, r[k], 1'b0);
        chk("rst_busy", k, busy[k], 1'b0);
        chk("rst_conflict", k, conflict[k], 1'b0);
      end
    end
    for (int e = 1; e <= 8; e++) begin
      tick(1, 0, 1);
      chk("lat_s_d4", 0, s[0], e == 7);
      chk("lat_s_d2", 2, s[2], e >= 5 && e <= 7);
    end
    settle();

    // Two-cycle glitch is below the 4-cycle debounce.
    tick(1, 0, 1);
    tick(1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 1);
      chk("glitch_s", 0, s[0], 1'b0);
      chk("glitch_busy", 0, busy[0], 1'b0);
    end
    settle();

    // Simultaneous rise of both requests.
    for (int k = 0; k < 3; k++) begin sc[k] = 0; rc[k] = 0; cc[k] = 0; end
    for (int i = 0; i < 32; i++) begin
      tick(i < 12, i < 12, 1);
      for (int k = 0; k < 3; k++) begin
        sc[k] += int'(s[k]); rc[k] += int'(r[k]); cc[k] += int'(conflict[k]);
      end
    end
    chk("simul_r_count_rp1", 0, rc[0] == 1 && sc[0] == 0, 1'b1);
    chk("simul_conflict_rp1", 0, cc[0] == 1, 1'b1);
    chk("simul_s_count_rp0", 1, sc[1] == 1 && rc[1] == 0, 1'b1);
    chk("simul_conflict_rp0", 1, cc[1] == 1, 1'b1);
    chk("simul_r_count_pw3", 2, rc[2] == 3 && sc[2] == 0, 1'b1);
    settle();

    // Set, then a reset request whose event lands during the set pulse.
    for (int e = 1; e <= 20; e++) begin
      tick(1, e >= 3, 1);
      chk("queue_s_d4", 0, s[0], e == 7);
      chk("queue_r_d4", 0, r[0], e == 10);
      chk("queue_s_gap0", 1, s[1], e == 7);
      chk("queue_r_gap0", 1, r[1], e == 9);
      chk("queue_s_pw3", 2, s[2], e >= 5 && e <= 7);
      chk("queue_r_pw3", 2, r[2], e >= 11 && e <= 13);
      chk("queue_busy_pw3", 2, busy[2], (e >= 5 && e <= 9) || (e >= 11 && e <= 15));
    end
    settle();

    // Randomized levels, mostly long holds with some short glitches and rare resets.
    hold_s = 0; hold_r = 0; lvl_s = 0; lvl_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_s == 0) begin
        lvl_s  = $urandom_range(0, 1) != 0;
        hold_s = ($urandom_range(0, 9) < 7) ? $urandom_range(5, 25) : $urandom_range(1, 5);
        if ($urandom_range(0, 5) == 0) begin
          lvl_r = lvl_s; hold_r = hold_s;
        end
      end
      if (hold_r == 0) begin
        lvl_r  = $urandom_range(0, 1) != 0;
        hold_r = ($urandom_range(0, 9) < 7) ? $urandom_range(5, 25) : $urandom_range(1, 5);
      end
      hold_s--; hold_r--;
      tick(lvl_s, lvl_r, $urandom_range(0, 399) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_pulse_gen.md
Name: sr_pulse_gen

Overview:
- Upstream command stage for the team's SR flip-flop bank.
- Turns two raw, asynchronous, bouncy request lines (set button, reset button) into clean, mutually exclusive S/R pulses of fixed width, with a minimum gap between pulses.
- Guarantees the downstream flip-flop never sees S=1 and R=1 together, so the illegal (X) state is unreachable.
- Outputs connect directly to the S and R inputs of the flip-flop.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a level change; legal range ≥1.
- PULSE_WIDTH, 1, cycles S or R is held high per accepted request; legal range ≥1.
- GAP_CYCLES, 1, minimum low cycles on both S and R after a pulse before the next pulse; 0 is legal.
- RESET_PRIORITY, 1, when both requests are pending in IDLE: 1 serves reset, 0 serves set.
- CNT_W, 8, width of the debounce, pulse and gap counters; must hold max(DEBOUNCE_CYCLES, PULSE_WIDTH, GAP_CYCLES).

Ports:
- Clk  input  1  single clock; all logic on posedge.
- Rst_n  input  1  synchronous, active-low reset, sampled on posedge Clk.
- Set_req  input  1  raw asynchronous set request, active high.
- Reset_req  input  1  raw asynchronous reset request, active high.
- S  output  1  set pulse to the flip-flop; registered.
- R  output  1  reset pulse to the flip-flop; registered.
- Busy  output  1  high in PULSE_S, PULSE_R or GAP.
- Conflict  output  1  one-cycle flag when a simultaneous pending request is dropped.

Behaviour:
- Reset (Rst_n=0 at posedge):
  - S=0, R=0, Busy=0, Conflict=0; FSM=IDLE.
  - Synchronizers, debounced levels, counters and pending flags all cleared to 0.
  - Reset mid-pulse truncates the pulse: S/R go 0 on that edge.
- Synchronizer: each request passes through a 2-flop synchronizer.
- Debounce (per channel):
  - Counter increments on each edge where the synchronized level differs from the debounced level.
  - Counter clears on any edge where they are equal.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Event: a 0→1 flip of a debounced level sets that channel's pending flag on the same edge. A 1→0 flip generates nothing.
- Pending flags:
  - One flag per channel.
  - An event arriving while the flag is already set is coalesced (no count, no flag).
  - If set and clear hit on the same edge, set wins.
- FSM states: IDLE, PULSE_S, PULSE_R, GAP.
  - IDLE, only pend_s set: go to PULSE_S, S<=1, clear pend_s.
  - IDLE, only pend_r set: go to PULSE_R, R<=1, clear pend_r.
  - IDLE, both set: serve the channel selected by RESET_PRIORITY, clear both flags, Conflict<=1 for one cycle.
  - PULSE_x: hold the output high for exactly PULSE_WIDTH cycles. Then drop it and go to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP: S=R=0 for GAP_CYCLES cycles, then IDLE. Requests arriving in PULSE/GAP set pending and are served afterwards.
- Invariant: S&R is 0 on every cycle.
- Latency: from IDLE with no pending flags, S (or R) rises on posedge number DEBOUNCE_CYCLES+3, counting the edge that first samples the raw input high as edge 1.
- Back-to-back: with a request pending at the end of GAP, the next pulse starts on the edge after GAP ends (IDLE lasts one cycle).
- Glitches: raw pulses shorter than DEBOUNCE_CYCLES cycles (after sync) produce no output.

Optional Feature:
- Macro: SR_PULSE_SHADOW_EN.
- Defined:
  - Adds output port Q_shadow (1 bit, reset 0) tracking the expected flip-flop state: set to 1 at the end of each S pulse, cleared to 0 at the end of each R pulse.
  - A pending request that would not change Q_shadow (set while Q_shadow=1, reset while Q_shadow=0) is cleared in IDLE without a pulse, and the FSM stays in IDLE.
- Not defined: no Q_shadow port; every accepted request produces a pulse.

Test Plan:
- Reset: hold Rst_n=0 for 3 cycles with Set_req=1 -> S=R=Busy=Conflict=0 throughout; after release, S rises at edge DEBOUNCE_CYCLES+3 (=7 with defaults).
- Glitch filter: Set_req high for 2 cycles with DEBOUNCE_CYCLES=4 -> S never asserts, Busy stays 0.
- Basic set then reset, defaults: Set_req held, later Reset_req held -> S high 1 cycle, ≥1 idle gap, then R high 1 cycle; S&R never 1.
- Simultaneous: both requests rise on the same edge with RESET_PRIORITY=1 -> single R pulse, Conflict=1 for one cycle, no S pulse. Rerun with RESET_PRIORITY=0 -> single S pulse.
- Queued request: PULSE_WIDTH=3, GAP_CYCLES=2; Reset_req event lands during an S pulse -> S high 3 cycles, 2 gap cycles, 1 IDLE cycle, then R high 3 cycles.
- Shadow (SR_PULSE_SHADOW_EN): two set requests in sequence -> one S pulse only, Q_shadow=1; a following reset request -> R pulse, Q_shadow=0.
